// File: rtl/imm_extend_unit_if.sv
// Operand-in / result-out bundle for the immediate extender.
// The "master" side is the decode stage and execute stage together; "slave" is the extender.
interface imm_extend_unit_if #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 32,
  parameter int TAG_BITS = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_imm;
  logic [2:0]          in_mode;
  logic [TAG_BITS-1:0] in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic [TAG_BITS-1:0] out_tag;
  logic                out_err;
  logic                err_sticky;
  logic                clear_err;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready, clear_err,
    input  in_ready, out_valid, out_data, out_tag, out_err, err_sticky
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready, clear_err,
    output in_ready, out_valid, out_data, out_tag, out_err, err_sticky
  );
endinterface

// File: rtl/imm_extend_unit.sv
// Mode-selectable immediate extender between decode and execute.
// The result is computed once at acceptance and held in a two-entry skid
// buffer (R0 = output register, R1 = skid), so in_ready depends on
// registered state only and one operand per cycle is sustained.
module imm_extend_unit #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 32,
  parameter int TAG_BITS = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_extend_unit_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Returns {err, data}. Reserved modes give zero data with err set.
  function automatic logic [OUT_BITS:0] extend_imm(
    input logic [IN_BITS-1:0] imm,
    input logic [2:0]         mode
  );
    logic [OUT_BITS-1:0] sext;
    logic [OUT_BITS-1:0] res;
    logic                err;
    sext                = {OUT_BITS{imm[IN_BITS-1]}};
    sext[IN_BITS-1:0]   = imm;
    res                 = '0;
    err                 = 1'b0;
    case (mode)
      3'b000: res = sext;
      3'b001: res = OUT_BITS'(imm);
      3'b010: res = OUT_BITS'(imm) << (OUT_BITS - IN_BITS);
      3'b011: begin
        res      = {OUT_BITS{imm[7]}};
        res[7:0] = imm[7:0];
      end
      3'b100: res = OUT_BITS'(imm[7:0]);
      3'b101: res = sext << BR_SHIFT;
      default: begin
        res = '0;
        err = 1'b1;
      end
    endcase
    return {err, res};
  endfunction

  logic [1:0]          state;
  logic                in_ready_int;
  logic                out_valid_int;
  logic                in_fire;
  logic                out_fire;
  logic [OUT_BITS:0]   ext_p0;
  logic [OUT_BITS-1:0] ext_data_p0;
  logic                ext_err_p0;

  logic [OUT_BITS-1:0] r0_data_p1;
  logic [TAG_BITS-1:0] r0_tag_p1;
  logic                r0_err_p1;
  logic [OUT_BITS-1:0] r1_data_p1;
  logic [TAG_BITS-1:0] r1_tag_p1;
  logic                r1_err_p1;
  logic                sticky;

  assign in_ready_int  = (state != ST_TWO);
  assign out_valid_int = (state != ST_EMPTY);
  assign in_fire       = bus.in_valid & in_ready_int;
  assign out_fire      = out_valid_int & bus.out_ready;

  // Stage p0: combinational extension of the operand being offered
  assign ext_p0      = extend_imm(bus.in_imm, bus.in_mode);
  assign ext_data_p0 = ext_p0[OUT_BITS-1:0];
  assign ext_err_p0  = ext_p0[OUT_BITS];

  // Stage p1: skid-buffer state machine moving results through R0/R1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      r0_data_p1 <= '0;
      r0_tag_p1  <= '0;
      r0_err_p1  <= 1'b0;
      r1_data_p1 <= '0;
      r1_tag_p1  <= '0;
      r1_err_p1  <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            r0_data_p1 <= ext_data_p0;
            r0_tag_p1  <= bus.in_tag;
            r0_err_p1  <= ext_err_p0;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            r0_data_p1 <= ext_data_p0;
            r0_tag_p1  <= bus.in_tag;
            r0_err_p1  <= ext_err_p0;
          end else if (in_fire) begin
            r1_data_p1 <= ext_data_p0;
            r1_tag_p1  <= bus.in_tag;
            r1_err_p1  <= ext_err_p0;
            state      <= ST_TWO;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            r0_data_p1 <= r1_data_p1;
            r0_tag_p1  <= r1_tag_p1;
            r0_err_p1  <= r1_err_p1;
            state      <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Sticky reserved-mode flag; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
    end else if (in_fire && ext_err_p0) begin
      sticky <= 1'b1;
    end else if (bus.clear_err) begin
      sticky <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.out_valid  = out_valid_int;
  assign bus.out_data   = r0_data_p1;
  assign bus.out_tag    = r0_tag_p1;
  assign bus.out_err    = r0_err_p1;
  assign bus.err_sticky = sticky;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: default instance checked through an
// expected-result queue, narrow variant (8->16, shift 1) checked directly.
module tb_imm_extend_unit;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t q[$];
  exp_t pend;
  exp_t mon_e;

  logic [15:0] sw_imm  [7] = '{16'h8001, 16'h8001, 16'h1234, 16'h0080, 16'h12F0, 16'hFFFF, 16'h4000};
  logic [2:0]  sw_mode [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
  logic [31:0] sw_exp  [7] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFF80,
                               32'h000000F0, 32'hFFFFFFFC, 32'h00010000};

  imm_extend_unit_if #(.IN_BITS(16), .OUT_BITS(32), .TAG_BITS(5)) a ();
  imm_extend_unit_if #(.IN_BITS(8),  .OUT_BITS(16), .TAG_BITS(5)) b ();

  imm_extend_unit #(.IN_BITS(16), .OUT_BITS(32), .TAG_BITS(5), .BR_SHIFT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );
  imm_extend_unit #(.IN_BITS(8), .OUT_BITS(16), .TAG_BITS(5), .BR_SHIFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Scoreboard: pop/compare on out_fire, push on in_fire (sampled mid-cycle)
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
        n_out++;
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=output expected=no_output");
        end
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("out_data", a.out_data, mon_e.data);
          check("out_tag", 32'(a.out_tag), 32'(mon_e.tag));
          check("out_err", 32'(a.out_err), 32'(mon_e.err));
        end
      end
      if (a.in_valid === 1'b1 && a.in_ready === 1'b1) q.push_back(pend);
    end
  end

  // Offer an operand (called at posedge+1); returns at posedge+1 after it is taken
  task automatic drive(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag,
                       input logic [31:0] ed, input logic ee);
    int waited;
    waited     = 0;
    a.in_valid = 1'b1;
    a.in_imm   = imm;
    a.in_mode  = mode;
    a.in_tag   = tag;
    pend.data  = ed;
    pend.tag   = tag;
    pend.err   = ee;
    @(negedge clk);
    while (a.in_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    assert (waited < 20) else begin
      errors++;
      $error("FAIL accept_timeout observed=stalled expected=accepted tag=%0d", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic [7:0] imm, input logic [2:0] mode, input logic [15:0] ed,
                         input string name);
    b.in_valid = 1'b1;
    b.in_imm   = imm;
    b.in_mode  = mode;
    b.in_tag   = 5'd3;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(b.in_ready), 32'd1);
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(b.out_valid), 32'd1);
    check({name, "_data"}, 32'(b.out_data), 32'(ed));
    check({name, "_err"}, 32'(b.out_err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] si;
    int          base;
    rst_n       = 1'b0;
    a.in_valid  = 1'b0; a.in_imm = '0; a.in_mode = '0; a.in_tag = '0;
    a.out_ready = 1'b1; a.clear_err = 1'b0;
    b.in_valid  = 1'b0; b.in_imm = '0; b.in_mode = '0; b.in_tag = '0;
    b.out_ready = 1'b1; b.clear_err = 1'b0;
    pend.data = '0; pend.tag = '0; pend.err = 1'b0;

    #12;
    check("rst_out_valid", 32'(a.out_valid), 32'd0);
    check("rst_in_ready", 32'(a.in_ready), 32'd1);
    check("rst_out_data", a.out_data, 32'd0);
    check("rst_out_tag", 32'(a.out_tag), 32'd0);
    check("rst_out_err", 32'(a.out_err), 32'd0);
    check("rst_sticky", 32'(a.err_sticky), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // mode sweep, one operand at a time, result visible the cycle after acceptance
    for (int i = 0; i < 7; i++) begin
      drive(sw_imm[i], sw_mode[i], 5'(i + 1), sw_exp[i], 1'b0);
      a.in_valid = 1'b0;
      @(negedge clk);
      check("latency_valid", 32'(a.out_valid), 32'd1);
      @(posedge clk); #1;
    end

    // back-pressure: fill both entries, third operand waits
    a.out_ready = 1'b0;
    drive(16'h0001, 3'd0, 5'd1, 32'h1, 1'b0);
    drive(16'h0002, 3'd0, 5'd2, 32'h2, 1'b0);
    a.in_imm = 16'h0003; a.in_tag = 5'd3;
    pend.data = 32'h3; pend.tag = 5'd3; pend.err = 1'b0;
    @(negedge clk);
    check("bp_in_ready_full", 32'(a.in_ready), 32'd0);
    check("bp_head_tag", 32'(a.out_tag), 32'd1);
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_first_fire", 32'(a.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_back", 32'(a.in_ready), 32'd1);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    @(negedge clk);
    check("bp_tag3_valid", 32'(a.out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained", 32'(a.out_valid), 32'd0);
    @(posedge clk); #1;

    // streaming: one operand per cycle with no stall
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      si = 16'($urandom);
      a.in_valid = 1'b1; a.in_imm = si; a.in_mode = 3'd0; a.in_tag = 5'(i);
      pend.data = 32'($signed(si)); pend.tag = 5'(i); pend.err = 1'b0;
      @(negedge clk);
      check("stream_in_ready", 32'(a.in_ready), 32'd1);
      if (i > 0) check("stream_out_valid", 32'(a.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check("stream_count", 32'(n_out - base), 32'd16);

    // reserved modes and sticky flag
    drive(16'hABCD, 3'b110, 5'd7, 32'h0, 1'b1);
    a.in_valid = 1'b0;
    @(negedge clk);
    check("sticky_set", 32'(a.err_sticky), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(16'(16'h0010 + k), 3'd0, 5'(8 + k), 32'(16'h0010 + k), 1'b0);
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    check("sticky_hold", 32'(a.err_sticky), 32'd1);
    @(posedge clk); #1;
    a.clear_err = 1'b1;
    @(posedge clk); #1;
    a.clear_err = 1'b0;
    @(negedge clk);
    check("sticky_clear", 32'(a.err_sticky), 32'd0);
    @(posedge clk); #1;
    a.clear_err = 1'b1;
    drive(16'h1111, 3'b111, 5'd12, 32'h0, 1'b1);
    a.clear_err = 1'b0;
    a.in_valid = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", 32'(a.err_sticky), 32'd1);
    @(posedge clk); #1;

    // asynchronous reset while both entries are full
    a.out_ready = 1'b0;
    drive(16'h0005, 3'd0, 5'd13, 32'h5, 1'b0);
    drive(16'h0006, 3'd0, 5'd14, 32'h6, 1'b0);
    a.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(a.out_valid), 32'd0);
    check("mrst_out_data", a.out_data, 32'd0);
    check("mrst_in_ready", 32'(a.in_ready), 32'd1);
    check("mrst_out_tag", 32'(a.out_tag), 32'd0);
    check("mrst_sticky", 32'(a.err_sticky), 32'd0);
    q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    drive(16'h7FFF, 3'd0, 5'd15, 32'h00007FFF, 1'b0);
    a.in_valid = 1'b0;
    @(negedge clk);
    check("mrst_recover_valid", 32'(a.out_valid), 32'd1);
    @(posedge clk); #1;

    // narrow parameter variant
    drive_b(8'h80, 3'd0, 16'hFF80, "b_sext");
    drive_b(8'h5A, 3'd2, 16'h5A00, "b_upper");
    drive_b(8'hC0, 3'd5, 16'hFF80, "b_branch");

    check("sb_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
